// File: rtl/uart_alu_frame_engine.sv
// Framed command engine: SYNC, OPC, A, B, CHK in over the rx FIFO; status + LSB-first ALU result out over tx.
// Operands are only committed to the ALU once the whole frame checks out.
module uart_alu_frame_engine #(
    parameter int                   DATA_BITS   = 8,
    parameter int                   OP_BYTES    = 2,
    parameter int                   OPCODE_BITS = 6,
    parameter logic [DATA_BITS-1:0] SYNC_BYTE   = 8'hA5,
    parameter int                   TO_W        = 16,
    parameter int                   TIMEOUT     = 50000
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_rx_empty,
    input  logic [DATA_BITS-1:0]            i_r_data,
    output logic                            o_rd_uart,
    input  logic                            i_tx_full,
    output logic [DATA_BITS-1:0]            o_w_data,
    output logic                            o_wr_uart,
    output logic [DATA_BITS*OP_BYTES-1:0]   o_op_a,
    output logic [DATA_BITS*OP_BYTES-1:0]   o_op_b,
    output logic [OPCODE_BITS-1:0]          o_op_code,
    input  logic [DATA_BITS*OP_BYTES-1:0]   i_result,
    output logic                            o_busy,
    output logic [7:0]                      o_err_count
);
    localparam int OP_W  = DATA_BITS * OP_BYTES;
    localparam int CNT_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [CNT_W-1:0]     LAST_BYTE  = CNT_W'(OP_BYTES - 1);
    localparam logic [TO_W-1:0]      TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [DATA_BITS-1:0] ST_OK      = '0;
    localparam logic [DATA_BITS-1:0] ST_BAD_CHK = DATA_BITS'(1);
    localparam logic [DATA_BITS-1:0] ST_TIMEOUT = DATA_BITS'(2);
    localparam logic [DATA_BITS-1:0] ST_BAD_OPC = DATA_BITS'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_RX_A, S_RX_B, S_CHK, S_EXEC, S_TX_STAT, S_TX_RES
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       byte_cnt_reg;
    logic [DATA_BITS-1:0]   xor_reg;
    logic [DATA_BITS-1:0]   opc_sh_reg;
    logic [OP_W-1:0]        a_sh_reg;
    logic [OP_W-1:0]        b_sh_reg;
    logic [DATA_BITS-1:0]   status_reg;
    logic [OP_W-1:0]        res_reg;
    logic [TO_W-1:0]        to_cnt_reg;
    logic [7:0]             err_next;
    logic                   rx_state;
    logic                   pop;
    logic                   push;
    logic                   opc_bad;

    // IDLE pops too so garbage between frames is drained.
    assign rx_state  = (state_reg == S_IDLE) || (state_reg == S_OPC) || (state_reg == S_RX_A) ||
                       (state_reg == S_RX_B) || (state_reg == S_CHK);
    assign pop       = !i_reset && rx_state && !i_rx_empty;
    assign push      = !i_reset && ((state_reg == S_TX_STAT) || (state_reg == S_TX_RES)) && !i_tx_full;
    assign o_rd_uart = pop;
    assign o_wr_uart = push;
    assign o_w_data  = (state_reg == S_TX_RES) ? res_reg[DATA_BITS-1:0] : status_reg;
    assign o_busy    = (state_reg != S_IDLE);
    assign err_next  = (o_err_count == 8'hFF) ? 8'hFF : o_err_count + 8'd1;

    generate
        if (OPCODE_BITS < DATA_BITS) begin : g_opc_check
            assign opc_bad = |opc_sh_reg[DATA_BITS-1:OPCODE_BITS];
        end else begin : g_opc_full
            assign opc_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= S_IDLE;
            byte_cnt_reg <= '0;
            xor_reg      <= '0;
            opc_sh_reg   <= '0;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            status_reg   <= '0;
            res_reg      <= '0;
            to_cnt_reg   <= '0;
            o_op_a       <= '0;
            o_op_b       <= '0;
            o_op_code    <= '0;
            o_err_count  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pop && (i_r_data == SYNC_BYTE)) begin
                        state_reg    <= S_OPC;
                        xor_reg      <= '0;
                        to_cnt_reg   <= '0;
                        byte_cnt_reg <= '0;
                    end
                end
                S_OPC, S_RX_A, S_RX_B, S_CHK: begin
                    if (pop) begin
                        to_cnt_reg <= '0;
                        case (state_reg)
                            S_OPC: begin
                                opc_sh_reg   <= i_r_data;
                                xor_reg      <= xor_reg ^ i_r_data;
                                byte_cnt_reg <= '0;
                                state_reg    <= S_RX_A;
                            end
                            S_RX_A: begin
                                a_sh_reg[byte_cnt_reg*DATA_BITS +: DATA_BITS] <= i_r_data;
                                xor_reg <= xor_reg ^ i_r_data;
                                if (byte_cnt_reg == LAST_BYTE) begin
                                    byte_cnt_reg <= '0;
                                    state_reg    <= S_RX_B;
                                end else begin
                                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                                end
                            end
                            S_RX_B: begin
                                b_sh_reg[byte_cnt_reg*DATA_BITS +: DATA_BITS] <= i_r_data;
                                xor_reg <= xor_reg ^ i_r_data;
                                if (byte_cnt_reg == LAST_BYTE) begin
                                    byte_cnt_reg <= '0;
                                    state_reg    <= S_CHK;
                                end else begin
                                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                                end
                            end
                            default: begin
                                // Checksum error outranks a bad opcode.
                                if (i_r_data != xor_reg) begin
                                    status_reg  <= ST_BAD_CHK;
                                    o_err_count <= err_next;
                                    state_reg   <= S_TX_STAT;
                                end else if (opc_bad) begin
                                    status_reg  <= ST_BAD_OPC;
                                    o_err_count <= err_next;
                                    state_reg   <= S_TX_STAT;
                                end else begin
                                    status_reg  <= ST_OK;
                                    o_op_a      <= a_sh_reg;
                                    o_op_b      <= b_sh_reg;
                                    o_op_code   <= opc_sh_reg[OPCODE_BITS-1:0];
                                    state_reg   <= S_EXEC;
                                end
                            end
                        endcase
                    end else if (to_cnt_reg == TO_LAST) begin
                        status_reg  <= ST_TIMEOUT;
                        o_err_count <= err_next;
                        to_cnt_reg  <= '0;
                        state_reg   <= S_TX_STAT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                S_EXEC: begin
                    res_reg      <= i_result;
                    byte_cnt_reg <= '0;
                    state_reg    <= S_TX_STAT;
                end
                S_TX_STAT: begin
                    if (push) begin
                        byte_cnt_reg <= '0;
                        state_reg    <= (status_reg == ST_OK) ? S_TX_RES : S_IDLE;
                    end
                end
                S_TX_RES: begin
                    if (push) begin
                        res_reg <= res_reg >> DATA_BITS;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            byte_cnt_reg <= '0;
                            state_reg    <= S_IDLE;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_frame_engine.sv
// Directed bench for uart_alu_frame_engine: FWFT rx FIFO model, tx capture, small ALU,
// hand-computed frames and responses.
module tb_uart_alu_frame_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [5:0]  op_code;
    logic [15:0] result;
    logic        busy;
    logic [7:0]  err_count;

    logic [7:0]  rx_mem [0:255];
    int          rx_head = 0;
    int          rx_tail = 0;
    logic [7:0]  tx_mem [0:63];
    int          tx_n = 0;
    logic        pop_seen = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign rx_empty = (rx_head == rx_tail);
    assign r_data   = rx_mem[rx_head[7:0]];
    assign result   = (op_code == 6'h20) ? op_a + op_b : op_a ^ op_b;

    uart_alu_frame_engine #(
        .DATA_BITS(8), .OP_BYTES(2), .OPCODE_BITS(6), .SYNC_BYTE(8'hA5), .TO_W(16), .TIMEOUT(100)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_empty(rx_empty), .i_r_data(r_data), .o_rd_uart(rd_uart),
        .i_tx_full(tx_full), .o_w_data(w_data), .o_wr_uart(wr_uart), .o_op_a(op_a), .o_op_b(op_b),
        .o_op_code(op_code), .i_result(result), .o_busy(busy), .o_err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Strobes are sampled mid-cycle; the FIFO pop takes effect at the following edge.
    always @(negedge clk) begin
        pop_seen = rd_uart;
        if (rd_uart) check("pop_while_empty", 32'(rx_empty), 32'h0);
        if (wr_uart) begin
            check("write_while_full", 32'(tx_full), 32'h0);
            $display("tx byte %0d = %02h", tx_n, w_data);
            if (tx_n < 64) tx_mem[tx_n] = w_data;
            tx_n = tx_n + 1;
        end
    end

    always @(posedge clk) if (pop_seen) rx_head <= rx_head + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_tail[7:0]] = b;
        rx_tail = rx_tail + 1;
    endtask

    task automatic push_frame(input logic [55:0] f);
        for (int i = 0; i < 7; i++) push(f[55-8*i -: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(rx_head == rx_tail && !busy) && n < 500) begin
            tick(1);
            n++;
        end
        check({tag, " idle_bound"}, 32'(n < 500), 32'h1);
    endtask

    task automatic run(input string tag, input logic [55:0] f, input int n, input logic [23:0] exp);
        int s;
        s = tx_n;
        push_frame(f);
        wait_idle(tag);
        $display("frame %s: %014h -> %0d tx bytes", tag, f, tx_n - s);
        check({tag, " tx_count"}, 32'(tx_n - s), 32'(n));
        for (int k = 0; k < n; k++)
            check({tag, " tx_byte"}, 32'(tx_mem[(s+k) % 64]), 32'(exp[23-8*k -: 8]));
    endtask

    task automatic check_ops(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [5:0] oc, input logic [7:0] ec);
        check({tag, " op_a"}, 32'(op_a), 32'(a));
        check({tag, " op_b"}, 32'(op_b), 32'(b));
        check({tag, " op_code"}, 32'(op_code), 32'(oc));
        check({tag, " err_count"}, 32'(err_count), 32'(ec));
        check({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int s;
        int h;
        rst = 1'b1;
        tx_full = 1'b0;
        tick(3);
        check("reset rd_uart", 32'(rd_uart), 32'h0);
        check("reset wr_uart", 32'(wr_uart), 32'h0);
        check("reset w_data", 32'(w_data), 32'h0);
        check_ops("reset", 16'h0, 16'h0, 6'h0, 8'd0);
        rst = 1'b0;
        tick(2);

        run("add", 56'hA5_20_34_12_01_00_07, 3, 24'h00_35_12);
        check_ops("add", 16'h1234, 16'h0001, 6'h20, 8'd0);

        run("bad_chk", 56'hA5_20_34_12_01_00_08, 1, 24'h01_00_00);
        check_ops("bad_chk", 16'h1234, 16'h0001, 6'h20, 8'd1);

        run("bad_opc", 56'hA5_E0_11_22_33_44_A4, 1, 24'h03_00_00);
        check_ops("bad_opc", 16'h1234, 16'h0001, 6'h20, 8'd2);

        run("chk_over_opc", 56'hA5_E0_11_22_33_44_00, 1, 24'h01_00_00);
        check_ops("chk_over_opc", 16'h1234, 16'h0001, 6'h20, 8'd3);

        // Garbage then a truncated frame: only the timeout status may come out.
        s = tx_n;
        h = rx_head;
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h20); push(8'h34);
        tick(90);
        check("timeout early_tx", 32'(tx_n - s), 32'h0);
        check("timeout busy", 32'(busy), 32'h1);
        check("timeout pops", 32'(rx_head - h), 32'd5);
        wait_idle("timeout");
        check("timeout tx_count", 32'(tx_n - s), 32'h1);
        check("timeout status", 32'(tx_mem[s % 64]), 32'h02);
        check_ops("timeout", 16'h1234, 16'h0001, 6'h20, 8'd4);

        run("carry", 56'hA5_20_FF_00_01_00_DE, 3, 24'h00_00_01);
        check_ops("carry", 16'h00FF, 16'h0001, 6'h20, 8'd4);

        run("sync_data", 56'hA5_20_A5_00_01_00_84, 3, 24'h00_A6_00);
        check_ops("sync_data", 16'h00A5, 16'h0001, 6'h20, 8'd4);

        // Tx held full well past the CHK pop.
        tx_full = 1'b1;
        s = tx_n;
        push_frame(56'hA5_20_34_12_01_00_07);
        tick(20);
        check("bp held_tx", 32'(tx_n - s), 32'h0);
        check("bp busy", 32'(busy), 32'h1);
        tx_full = 1'b0;
        wait_idle("bp");
        check("bp tx_count", 32'(tx_n - s), 32'd3);
        check("bp byte0", 32'(tx_mem[s % 64]), 32'h00);
        check("bp byte1", 32'(tx_mem[(s+1) % 64]), 32'h35);
        check("bp byte2", 32'(tx_mem[(s+2) % 64]), 32'h12);
        check_ops("bp", 16'h1234, 16'h0001, 6'h20, 8'd4);

        // Reset in the middle of a frame.
        s = tx_n;
        push(8'hA5); push(8'h20); push(8'h34);
        tick(5);
        check("midrst busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(1);
        check("midrst wr_uart", 32'(wr_uart), 32'h0);
        check("midrst rd_uart", 32'(rd_uart), 32'h0);
        check("midrst w_data", 32'(w_data), 32'h0);
        check_ops("midrst", 16'h0, 16'h0, 6'h0, 8'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("midrst no_tx", 32'(tx_n - s), 32'h0);

        run("after_rst", 56'hA5_20_05_00_03_00_26, 3, 24'h00_08_00);
        check_ops("after_rst", 16'h0005, 16'h0003, 6'h20, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_alu_frame_engine.md
Name: uart_alu_frame_engine

Overview:
- Framed command engine between the UART FIFO interface (rx/tx FIFO handshakes) and the combinational ALU.
- Parametrised successor of the simple byte-sequence interface: multi-byte operands, sync-byte framing, XOR checksum, inter-byte timeout, and a status byte on every response.
- Operands reach the ALU only after a frame validates. The result is returned LSB-first.

Parameters:
- DATA_BITS, 8: UART word width.
- OP_BYTES, 2: bytes per operand. OP_W = DATA_BITS*OP_BYTES is a localparam.
- OPCODE_BITS, 6: ALU opcode width, must be <= DATA_BITS.
- SYNC_BYTE, 8'hA5: frame start marker.
- TO_W, 16: timeout counter width.
- TIMEOUT, 50000: idle clocks allowed between bytes inside a frame.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_empty  in  1  rx FIFO empty.
- i_r_data  in  DATA_BITS  rx FIFO head word, first-word-fall-through.
- o_rd_uart  out  1  rx FIFO pop strobe.
- i_tx_full  in  1  tx FIFO full.
- o_w_data  out  DATA_BITS  tx word.
- o_wr_uart  out  1  tx FIFO push strobe.
- o_op_a  out  OP_W  ALU operand A.
- o_op_b  out  OP_W  ALU operand B.
- o_op_code  out  OPCODE_BITS  ALU opcode.
- i_result  in  OP_W  ALU result, combinational from o_op_*.
- o_busy  out  1  high whenever state != IDLE.
- o_err_count  out  8  saturating count of error responses.

Behaviour:
- Reset: all outputs and state registers go to 0, state goes to IDLE. Reset mid-frame or mid-response discards everything; no partial tx completes.
- Frame format: SYNC, OPC, A[0..OP_BYTES-1], B[0..OP_BYTES-1], CHK. Operand bytes are LSB first. CHK = XOR of all bytes after SYNC, excluding CHK itself.
- Rx handshake: in a receive state with !i_rx_empty, drive o_rd_uart=1 for exactly one cycle and capture i_r_data in that same cycle. Never pop while i_rx_empty=1.
- Tx handshake: o_wr_uart=1 for one cycle with o_w_data valid, only when i_tx_full=0. While i_tx_full=1, hold state and data and do not write.
- FSM states: IDLE, OPC, RX_A, RX_B, CHK, EXEC, TX_STAT, TX_RES.
- IDLE: pop every byte. A non-SYNC byte is discarded and state stays IDLE. SYNC goes to OPC and clears the running XOR.
- OPC, RX_A, RX_B: assemble into shadow registers. A byte counter (range 0..OP_BYTES-1) wraps to 0 on each state change.
- CHK: on pop, compare against the running XOR. Status is resolved in this priority order:
  - checksum mismatch: 8'h01.
  - opcode byte upper bits [DATA_BITS-1:OPCODE_BITS] nonzero: 8'h03.
  - otherwise: 8'h00.
- On status 00: commit shadow registers to o_op_a, o_op_b and o_op_code at that clock edge, then go to EXEC.
- On error: go to TX_STAT. o_op_* are unchanged and o_err_count increments (saturates at 255).
- EXEC: one cycle. Latch i_result into the result shift register, then go to TX_STAT.
- Latency: first o_wr_uart (status byte) is 2 cycles after the CHK pop on success, and 1 cycle after on error, assuming tx is not full.
- TX_STAT: send the status byte. Status 00 goes to TX_RES; any error goes to IDLE.
- TX_RES: send OP_BYTES result bytes, LSB first, then go to IDLE.
- Timeout: the counter clears on every pop and on entering OPC. In OPC, RX_A, RX_B and CHK it increments each cycle with no pop.
  - When it reaches TIMEOUT-1, go to TX_STAT with status 8'h02 and increment o_err_count. No commit occurs.
  - A pop in the same cycle as the terminal count takes priority: the byte is accepted and the counter clears.
  - The counter is inactive in IDLE, EXEC and the TX states.
- The rx FIFO is not read during EXEC or the TX states; bytes remain queued.
- A SYNC value appearing mid-frame is treated as ordinary data.

Test Plan (OP_BYTES=2, OPCODE_BITS=6, ALU ADD=6'h20, TIMEOUT=100 for sim):
- Basic add: feed A5 20 34 12 01 00 07 -> o_op_a=16'h1234, o_op_b=16'h0001, o_op_code=6'h20. Tx sequence 00 35 12. o_err_count=0. o_busy returns to 0.
- Bad checksum: same frame with CHK=08 -> tx 01 only. o_op_* keep prior values. o_err_count=1.
- Bad opcode: A5 E0 34 12 01 00 C7 (valid XOR) -> tx 03. o_op_* unchanged. o_err_count increments.
- Timeout and garbage: feed 00 FF A5 20 34, then nothing for 100 cycles -> 00 and FF are popped and discarded. Status 02 is sent at timeout. Next a full valid frame is processed normally.
- Backpressure: valid frame with i_tx_full held high 10 cycles after CHK -> no o_wr_uart while full. After release, tx 00 35 12 in order, with no loss or duplication.
- Reset mid-frame: assert i_reset after A5 20 34 -> all outputs 0, state IDLE. The following complete frame yields the correct response.
